// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky error flags, synchronous flush and standard/FWFT read modes.
module sync_fifo_flex #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   clr_err,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             rd_acc, wr_acc, mem_we;

    // All status flags derive from the count register alone.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ovf_d      = clr_err ? 1'b0 : ovf_q;
        unf_d      = clr_err ? 1'b0 : unf_q;
        rd_acc     = rd_en && !empty;
        // A read frees a slot in the same edge, so a full FIFO still takes the write.
        wr_acc     = wr_en && (!full || rd_acc);
        mem_we     = 1'b0;
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            rd_data_d = '0;
        end else begin
            mem_we     = wr_acc;
            rd_valid_d = rd_acc;
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                rd_data_d = mem_q[rd_ptr_q];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en && !wr_acc) ovf_d = 1'b1;
            if (rd_en && empty)   unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= wr_data;
    end

    // FWFT presents the head word combinationally; standard mode uses the read register.
    assign rd_data  = (FWFT != 0) ? (empty ? '0 : mem_q[rd_ptr_q]) : rd_data_q;
    assign rd_valid = (FWFT != 0) ? !empty : rd_valid_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Randomised and directed bench for sync_fifo_flex; one standard and one FWFT
// instance share stimulus and are compared against a queue-based model.
module tb_sync_fifo_flex;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst, flush, clr_err, wr_en, rd_en;
    logic [7:0] wr_data;

    logic [7:0] s_rd_data, f_rd_data;
    logic s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [4:0] s_count, f_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic [7:0] m_rd;
    logic m_v, m_ovf, m_unf;

    always #5 clk = ~clk;

    sync_fifo_flex #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf));

    sync_fifo_flex #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd = '0; m_v = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic model_edge();
        bit rd_ok, wr_ok;
        int n;
        n = mq.size();
        if (clr_err) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (flush) begin
            mq.delete(); m_rd = '0; m_v = 1'b0;
        end else begin
            rd_ok = rd_en && (n > 0);
            wr_ok = wr_en && ((n < DEPTH) || rd_ok);
            if (wr_en && !wr_ok) m_ovf = 1'b1;
            if (rd_en && n == 0) m_unf = 1'b1;
            m_v = rd_ok;
            if (rd_ok) m_rd = mq.pop_front();
            if (wr_ok) mq.push_back(wr_data);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count",     32'(s_count), 32'(n));
        chk("full",      32'(s_full), 32'(n == DEPTH));
        chk("empty",     32'(s_empty), 32'(n == 0));
        chk("afull",     32'(s_af), 32'(n >= 14));
        chk("aempty",    32'(s_ae), 32'(n <= 2));
        chk("overflow",  32'(s_ovf), 32'(m_ovf));
        chk("underflow", 32'(s_unf), 32'(m_unf));
        chk("std_valid", 32'(s_rd_valid), 32'(m_v));
        chk("std_data",  32'(s_rd_data), 32'(m_rd));
        chk("fw_count",  32'(f_count), 32'(n));
        chk("fw_flags",  32'({f_full, f_empty, f_af, f_ae, f_ovf, f_unf}),
            32'({n == DEPTH, n == 0, n >= 14, n <= 2, m_ovf, m_unf}));
        chk("fw_valid",  32'(f_rd_valid), 32'(n != 0));
        chk("fw_data",   32'(f_rd_data), 32'(n != 0 ? mq[0] : 8'h00));
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f = 0, input bit c = 0);
        @(negedge clk);
        wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c;
        @(posedge clk);
        model_edge();
        #1 check_all();
    endtask

    task automatic idle();
        step(0, 8'h00, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 0; clr_err = 0; wr_en = 0; rd_en = 0; wr_data = 0;
        model_reset();
        #12 check_all();
        @(negedge clk) rst = 1'b0;

        // Fill and drain
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        chk("fill_full", 32'(s_full), 32'h1);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1);
            chk("drain_data", 32'(s_rd_data), 32'(i));
        end
        idle();
        chk("drain_empty", 32'(s_empty), 32'h1);

        // Bursts across pointer wrap
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0);
            for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
        end
        idle();

        // Simultaneous read/write at full
        for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0);
        step(1, 8'hAA, 1);
        chk("full_rw_count", 32'(s_count), 32'd16);
        chk("full_rw_ovf", 32'(s_ovf), 32'h0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
        chk("aa_last", 32'(s_rd_data), 32'hAA);

        // Simultaneous read/write at empty
        step(1, 8'h55, 1);
        chk("empty_rw_count", 32'(s_count), 32'd1);
        chk("empty_rw_unf", 32'(s_unf), 32'h1);
        step(0, 8'h00, 1);
        chk("read_55", 32'(s_rd_data), 32'h55);
        step(0, 8'h00, 0, 0, 1);

        // Sticky errors and clr_err priority
        for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0);
        step(1, 8'hEE, 0);
        for (int i = 0; i < 17; i++) step(0, 8'h00, 1);
        chk("ovf_sticky", 32'(s_ovf), 32'h1);
        chk("unf_sticky", 32'(s_unf), 32'h1);
        step(0, 8'h00, 1, 0, 1);
        chk("clr_vs_unf", 32'({s_ovf, s_unf}), 32'b01);
        step(0, 8'h00, 0, 0, 1);

        // FWFT visibility
        step(1, 8'h3C, 0);
        chk("fwft_3c", 32'({f_rd_valid, f_rd_data}), 32'h13C);
        step(0, 8'h00, 1);
        chk("fwft_pop", 32'({f_rd_valid, f_rd_data}), 32'h000);

        // Flush with concurrent write
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0);
        step(1, 8'h77, 0, 1, 0);
        chk("flush_count", 32'(s_count), 32'd0);
        chk("flush_ovf", 32'(s_ovf), 32'h0);

        // Randomised traffic
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 6; i++) step(1, 8'($urandom), 0);
        step(0, 8'h00, 1);
        @(negedge clk) wr_en = 1; wr_data = 8'h99; rd_en = 0;
        @(posedge clk) model_edge();
        #2 rst = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk) rst = 1'b0; wr_en = 0;
        for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), i > 1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
